// File: rtl/div_seq.sv
// Sequential restoring divider: DW-bit unsigned dividend by VW-bit unsigned divisor,
// one quotient bit per clock, with a start/busy/done handshake.
module div_seq #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero,
    output logic [1:0]    dbg_state
);

    // Handshake: start is sampled only in IDLE. Operands are captured on the accepting
    // edge. done pulses for one cycle with results valid. Results hold until the next accept.
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [VW-1:0] p_q;
    logic [DW-1:0] q_q;
    logic [VW-1:0] dvs_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] quo_q;
    logic [VW-1:0] rem_q;
    logic          dz_q;

    logic [VW:0]   t_w;
    logic          ge_w;
    logic [VW-1:0] p_d;
    logic [DW-1:0] q_d;

    // A partial remainder is always below the divisor, so P keeps only VW bits.
    // T still needs VW+1 bits for the compare.
    always_comb begin
        t_w  = {p_q, q_q[DW-1]};
        ge_w = (t_w >= {1'b0, dvs_q});
        p_d  = ge_w ? VW'(t_w - {1'b0, dvs_q}) : t_w[VW-1:0];
        q_d  = {q_q[DW-2:0], ge_w};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            dvs_q   <= divisor;
                            p_q     <= '0;
                            q_q     <= dividend;
                            cnt_q   <= CW'(DW - 1);
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            quo_q   <= '1;
                            rem_q   <= '0;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    p_q <= p_d;
                    q_q <= q_d;
                    if (cnt_q == '0) begin
                        quo_q   <= q_d;
                        rem_q   <= p_d;
                        dz_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: queued expectations from an arithmetic model, checked by a
// negedge monitor whenever done is seen.
module tb_div_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;
    logic [1:0] dbg_state;

    div_seq #(.DW(8), .VW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ncnt  = 0;
    int bc    = 0;

    // Expected word: {latency[20:17], busy cycles[16:13], div_zero[12], rem[11:8], quo[7:0]}
    logic [20:0] exp_q[$];
    int          acc_q[$];
    logic [20:0] mon_e;
    int          mon_acc;

    function automatic logic [20:0] model(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] qv;
        logic [3:0] rv;
        logic       dz;
        logic [3:0] lat;
        logic [3:0] bz;
        if (b == 4'd0) begin
            qv = 8'd255; rv = 4'd0; dz = 1'b1; lat = 4'd1; bz = 4'd0;
        end else begin
            qv = a / {4'd0, b};
            rv = 4'(a % {4'd0, b});
            dz = 1'b0; lat = 4'd9; bz = 4'd8;
        end
        return {lat, bz, dz, rv, qv};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts negedges, tracks busy cycles, pops one expectation per done pulse.
    always @(negedge clk) begin
        ncnt++;
        if (!rst_n) begin
            bc = 0;
        end else begin
            check("busy_done_exclusive", int'(busy && done), 0);
            if (busy) bc++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_acc = acc_q.pop_front();
                    check("quotient", int'(quotient), int'(mon_e[7:0]));
                    check("remainder", int'(remainder), int'(mon_e[11:8]));
                    check("div_zero", int'(div_zero), int'(mon_e[12]));
                    check("done_latency", ncnt - mon_acc, int'(mon_e[20:17]));
                    check("busy_cycles", bc, int'(mon_e[16:13]));
                end
                bc = 0;
            end
        end
    end

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk); #1;
    endtask

    // Called at negedge+1 with the DUT idle; returns one cycle later with start low.
    task automatic issue(input logic [7:0] a, input logic [3:0] b, input bit push);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (push) begin
            exp_q.push_back(model(a, b));
            acc_q.push_back(ncnt);
        end
        @(negedge clk); #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_quotient"}, int'(quotient), 0);
        check({tag, "_remainder"}, int'(remainder), 0);
        check({tag, "_div_zero"}, int'(div_zero), 0);
    endtask

    logic [7:0] a_tab [7] = '{8'd200, 8'd255, 8'd5, 8'd0, 8'd255, 8'd100, 8'd9};
    logic [3:0] b_tab [7] = '{4'd7, 4'd1, 4'd9, 4'd15, 4'd15, 4'd0, 4'd3};
    logic [7:0] q_tab [7] = '{8'd28, 8'd255, 8'd0, 8'd0, 8'd17, 8'd255, 8'd3};
    logic [3:0] r_tab [7] = '{4'd4, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       z_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int acc;
        int nxt;
        logic [7:0] ha;
        logic [3:0] hb;

        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            issue(a_tab[i], b_tab[i], 1'b1);
            wait_drain();
            check("table_quotient", int'(quotient), int'(q_tab[i]));
            check("table_remainder", int'(remainder), int'(r_tab[i]));
            check("table_div_zero", int'(div_zero), int'(z_tab[i]));
        end

        // Start pulse and operand changes mid-RUN must not disturb the original operation.
        issue(8'd200, 4'd7, 1'b1);
        repeat (3) begin @(negedge clk); #1; end
        start    = 1'b1;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        @(negedge clk); #1;
        start    = 1'b0;
        divisor  = 4'd0;
        wait_drain();
        repeat (12) begin @(negedge clk); #1; end

        // start held high: accepts every 10 cycles, or every 2 for a zero divisor.
        acc   = ncnt;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ha = 8'($urandom_range(0, 255));
            hb = (i == 1 || i == 2) ? 4'd0 : 4'($urandom_range(1, 15));
            dividend = ha;
            divisor  = hb;
            exp_q.push_back(model(ha, hb));
            acc_q.push_back(acc);
            nxt = acc + ((hb == 4'd0) ? 2 : 10);
            @(negedge clk); #1;
            if (i == 4) start = 1'b0;
            while (ncnt < nxt) begin @(negedge clk); #1; end
            acc = nxt;
        end
        wait_drain();

        // Reset mid-operation aborts with no done pulse.
        issue(8'd200, 4'd7, 1'b1);
        wait_drain();
        issue(8'd200, 4'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (15) begin @(negedge clk); #1; end
        issue(8'd50, 4'd6, 1'b1);
        wait_drain();
        check("after_reset_quotient", int'(quotient), 8);
        check("after_reset_remainder", int'(remainder), 2);

        for (int i = 0; i < 200; i++) begin
            issue(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b1);
            wait_drain();
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(8'(a), 4'(b), 1'b1);
                wait_drain();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
